// File: rtl/line_buffer_window_if.sv
// Pixel stream in, line-buffer BRAM ports and 3x3 window out for line_buffer_window.
// slave is the window block's view; master is the view of whatever surrounds it.
interface line_buffer_window_if #(
   parameter int WIDTH = 8
);
   logic               in_valid;
   logic               in_sof;
   logic [WIDTH-1:0]   in_data;

   logic               lb_re_b;
   logic [10:0]        lb_addr_b;
   logic [WIDTH-1:0]   lb0_dout_b;
   logic [WIDTH-1:0]   lb1_dout_b;

   logic               lb_we_a;
   logic [10:0]        lb_addr_a;
   logic [WIDTH-1:0]   lb0_din_a;
   logic [WIDTH-1:0]   lb1_din_a;

   logic               win_valid;
   logic [9*WIDTH-1:0] win_data;
   logic               win_last;

   modport slave (
      input  in_valid, in_sof, in_data, lb0_dout_b, lb1_dout_b,
      output lb_re_b, lb_addr_b, lb_we_a, lb_addr_a, lb0_din_a, lb1_din_a,
      output win_valid, win_data, win_last
   );

   modport master (
      output in_valid, in_sof, in_data, lb0_dout_b, lb1_dout_b,
      input  lb_re_b, lb_addr_b, lb_we_a, lb_addr_a, lb0_din_a, lb1_din_a,
      input  win_valid, win_data, win_last
   );
endinterface

// File: rtl/line_buffer_window.sv
// Raster pixels in, 3x3 interior windows out, using two external line-buffer BRAMs
// (LB0 = row y-1, LB1 = row y-2) that are rotated one row down per accepted pixel.
module line_buffer_window #(
   parameter int IMG_WIDTH  = 1920,
   parameter int IMG_HEIGHT = 1080,
   parameter int WIDTH      = 8
) (
   input  logic                clk,
   input  logic                rst,
   line_buffer_window_if.slave bus
);
   localparam logic [10:0] LAST_COL = 11'(IMG_WIDTH - 1);
   localparam logic [10:0] LAST_ROW = 11'(IMG_HEIGHT - 1);

   logic [10:0]                col, row;
   logic [10:0]                cur_x, cur_y;
   logic                       v_d;
   logic [WIDTH-1:0]           p_d;
   logic [10:0]                x_d, y_d;
   logic [2:0][2:0][WIDTH-1:0] win_q;
   logic                       win_valid_q, win_last_q;
   logic                       win_hit, frame_end;

   // in_sof forces the current pixel to (0,0); everything downstream uses cur_x/cur_y.
   assign cur_x = bus.in_sof ? 11'd0 : col;
   assign cur_y = bus.in_sof ? 11'd0 : row;

   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (bus.in_valid) begin
         if (cur_x == LAST_COL) begin
            col <= '0;
            row <= (cur_y == LAST_ROW) ? 11'd0 : cur_y + 11'd1;
         end else begin
            col <= cur_x + 11'd1;
            row <= cur_y;
         end
      end
   end

   // Read side: the BRAMs latch this address on the accept edge.
   assign bus.lb_re_b   = bus.in_valid;
   assign bus.lb_addr_b = cur_x;

   always_ff @(posedge clk) begin
      if (rst) begin
         v_d <= 1'b0;
         p_d <= '0;
         x_d <= '0;
         y_d <= '0;
      end else begin
         v_d <= bus.in_valid;
         if (bus.in_valid) begin
            p_d <= bus.in_data;
            x_d <= cur_x;
            y_d <= cur_y;
         end
      end
   end

   // Write side: the column moves down one row (pixel -> LB0, old LB0 -> LB1).
   // Write address x_d never collides with the concurrent read of x_d+1 or 0.
   assign bus.lb_we_a   = v_d;
   assign bus.lb_addr_a = x_d;
   assign bus.lb0_din_a = p_d;
   assign bus.lb1_din_a = bus.lb0_dout_b;

   // y_d>=2 also masks stale line-buffer rows left from an earlier or aborted frame.
   assign win_hit   = v_d && (x_d >= 11'd2) && (y_d >= 11'd2);
   assign frame_end = (x_d == LAST_COL) && (y_d == LAST_ROW);

   always_ff @(posedge clk) begin
      if (rst) begin
         win_q       <= '0;
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
      end else begin
         win_valid_q <= win_hit;
         win_last_q  <= win_hit && frame_end;
         if (v_d) begin
            for (int r = 0; r < 3; r++) begin
               win_q[r][0] <= win_q[r][1];
               win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= bus.lb1_dout_b;
            win_q[1][2] <= bus.lb0_dout_b;
            win_q[2][2] <= p_d;
         end
      end
   end

   // Packed [r][c] ordering puts element r*3+c at bits [(r*3+c)*WIDTH +: WIDTH].
   assign bus.win_valid = win_valid_q;
   assign bus.win_last  = win_last_q;
   assign bus.win_data  = win_q;

endmodule

// File: tb/tb_line_buffer_window.sv
// Directed bench for line_buffer_window on a 4x4 image with a behavioural BRAM pair.
module tb_line_buffer_window;
   localparam int W = 4;
   localparam int H = 4;

   typedef struct {
      int          x;
      int          y;
      logic [71:0] win;
      logic        last;
   } win_vec_t;

   typedef struct {
      logic        valid;
      logic        last;
      logic        after_v;
      logic [71:0] win;
      int          cyc;
   } win_obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   win_vec_t tbl [4];
   win_obs_t obs [$];
   int       samp_q [$];
   logic     prev_we = 1'b0;

   logic [7:0] mem0 [2048];
   logic [7:0] mem1 [2048];

   line_buffer_window_if #(.WIDTH(8)) bus ();

   line_buffer_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Single-write/single-read BRAMs with registered read data.
   always @(posedge clk) begin
      if (bus.lb_re_b) begin
         bus.lb0_dout_b <= mem0[bus.lb_addr_b];
         bus.lb1_dout_b <= mem1[bus.lb_addr_b];
      end
      if (bus.lb_we_a) begin
         mem0[bus.lb_addr_a] <= bus.lb0_din_a;
         mem1[bus.lb_addr_a] <= bus.lb1_din_a;
      end
   end

   always @(negedge clk) begin
      if (!rst && (bus.win_valid || bus.win_last))
         obs.push_back('{bus.win_valid, bus.win_last, prev_we, bus.win_data, cyc});
      prev_we <= bus.lb_we_a;
   end

   function automatic logic [71:0] w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
      return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
   endfunction

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // exp_lb1 < 0 skips the LB1 write-data check (stale contents of unknown origin).
   task automatic send(input logic sof, input int x, input int y, input int exp_lb1);
      bus.in_valid = 1'b1;
      bus.in_sof   = sof;
      bus.in_data  = 8'(16 * y + x);
      #1;
      check("lb_re_b", 72'(bus.lb_re_b), 72'd1);
      check("lb_addr_b", 72'(bus.lb_addr_b), 72'(x));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      if (x == 2 && y == 2) samp_q.push_back(cyc);
      check("lb_we_a", 72'(bus.lb_we_a), 72'd1);
      check("lb_addr_a", 72'(bus.lb_addr_a), 72'(x));
      check("lb0_din_a", 72'(bus.lb0_din_a), 72'(16 * y + x));
      if (exp_lb1 >= 0) check("lb1_din_a", 72'(bus.lb1_din_a), 72'(exp_lb1));
   endtask

   task automatic run_frame(input logic sof_first, input logic gaps, input logic fresh);
      int lb1;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            lb1 = (y >= 1) ? 16 * (y - 1) + x : (fresh ? 'hEE : -1);
            send(sof_first && x == 0 && y == 0, x, y, lb1);
            if (gaps && $urandom_range(1, 0) == 1) idle($urandom_range(2, 1));
         end
      end
   endtask

   task automatic cmp_windows(input string tag, input int nframes);
      int nlast = 0;
      check({tag, "_count"}, 72'(obs.size()), 72'(4 * nframes));
      for (int i = 0; i < obs.size() && i < 4 * nframes; i++) begin
         check({tag, "_valid"}, 72'(obs[i].valid), 72'd1);
         check({tag, "_after_v"}, 72'(obs[i].after_v), 72'd1);
         check({tag, "_data"}, obs[i].win, tbl[i % 4].win);
         check({tag, "_last"}, 72'(obs[i].last), 72'(tbl[i % 4].last));
         if (obs[i].last) nlast++;
      end
      check({tag, "_nlast"}, 72'(nlast), 72'(nframes));
      check({tag, "_nsamp"}, 72'(samp_q.size()), 72'(nframes));
      for (int f = 0; f < nframes && f < samp_q.size() && 4 * f < obs.size(); f++)
         check({tag, "_latency"}, 72'(obs[4 * f].cyc - samp_q[f]), 72'd1);
      obs.delete();
      samp_q.delete();
   endtask

   initial begin
      tbl[0] = '{2, 2, w9(0, 1, 2, 16, 17, 18, 32, 33, 34), 1'b0};
      tbl[1] = '{3, 2, w9(1, 2, 3, 17, 18, 19, 33, 34, 35), 1'b0};
      tbl[2] = '{2, 3, w9(16, 17, 18, 32, 33, 34, 48, 49, 50), 1'b0};
      tbl[3] = '{3, 3, w9(17, 18, 19, 33, 34, 35, 49, 50, 51), 1'b1};
      for (int i = 0; i < 2048; i++) begin
         mem0[i] = 8'hEE;
         mem1[i] = 8'hEE;
      end

      // Reset held with traffic present.
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_sof   = 1'b0;
      bus.in_data  = 8'hAA;
      repeat (3) @(posedge clk);
      #1;
      check("rst_win_valid", 72'(bus.win_valid), 72'd0);
      check("rst_win_last", 72'(bus.win_last), 72'd0);
      check("rst_win_data", bus.win_data, 72'd0);
      check("rst_lb_we_a", 72'(bus.lb_we_a), 72'd0);
      check("rst_lb_addr_a", 72'(bus.lb_addr_a), 72'd0);
      check("rst_lb0_din_a", 72'(bus.lb0_din_a), 72'd0);
      check("rst_lb_re_b", 72'(bus.lb_re_b), 72'd1);
      rst = 1'b0;
      idle(2);
      check("rst_no_windows", 72'(obs.size()), 72'd0);

      // Continuous frame, including BRAM port checks against fresh memory.
      run_frame(1'b1, 1'b0, 1'b1);
      idle(4);
      cmp_windows("cont", 1);
      idle(3);
      check("win_data_hold", bus.win_data, tbl[3].win);
      check("win_valid_idle", 72'(bus.win_valid), 72'd0);

      // Same frame with random input gaps.
      run_frame(1'b1, 1'b1, 1'b0);
      idle(4);
      cmp_windows("gaps", 1);

      // Abort after 10 pixels, restart with in_sof.
      for (int i = 0; i < 10; i++)
         send(i == 0, i % W, i / W, (i / W >= 1) ? 16 * (i / W - 1) + i % W : -1);
      run_frame(1'b1, 1'b0, 1'b0);
      idle(4);
      cmp_windows("midsof", 1);

      // Two frames back to back, second relying on counter wrap.
      run_frame(1'b1, 1'b0, 1'b0);
      run_frame(1'b0, 1'b0, 1'b0);
      idle(4);
      cmp_windows("b2b", 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end
endmodule
